// File: rtl/alu_pkg.sv
// Shared constants for the ALU and its byte-serial front end: op codes,
// front-end state encoding and the byte-select helper.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_NOT  = 3'd7
    } alu_op_e;

    localparam logic [2:0] S_HDR  = 3'd0;
    localparam logic [2:0] S_A    = 3'd1;
    localparam logic [2:0] S_B    = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam logic [7:0] ERR_BYTE   = 8'hEE;
    localparam int         OPND_BYTES = 4;
    localparam logic [1:0] LAST_IDX   = 2'(OPND_BYTES - 1);

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/alu_byte_frontend_if.sv
// Byte-wide valid/ready command input and result output streams of the
// ALU front end; slave is the front end, master is the traffic source/sink.
interface alu_byte_frontend_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
endinterface

// File: rtl/alu_byte_frontend.sv
// Collects opcode + two 32-bit operands from a byte stream, drives them to
// the adjacent ALU, then returns the sampled ALU result as four bytes.
module alu_byte_frontend
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    alu_byte_frontend_if.slave   bus,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_op,
    input  logic [31:0]          alu_q,
    output logic                 busy
);

    logic [2:0]  state_r;
    logic [1:0]  k_r;
    logic [31:0] res_r;

    logic [2:0]  state_s;
    logic [1:0]  k_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [2:0]  op_s;
    logic [31:0] res_s;
    logic        in_ready_s;
    logic        out_valid_s;
    logic [7:0]  out_data_s;
    logic        in_fire_s;
    logic        out_fire_s;

    assign in_fire_s  = bus.in_valid  && bus.in_ready;
    assign out_fire_s = bus.out_valid && bus.out_ready;

    // Next-state, shared byte counter and operand/result shift logic.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        a_s     = alu_a;
        b_s     = alu_b;
        op_s    = alu_op;
        res_s   = res_r;
        case (state_r)
            S_HDR: begin
                if (in_fire_s) begin
                    if (bus.in_data[7:3] == 5'd0) begin
                        op_s    = bus.in_data[2:0];
                        state_s = S_A;
                    end else begin
                        state_s = S_ERR;
                    end
                end else begin
                    state_s = S_HDR;
                end
            end
            S_A: begin
                if (in_fire_s) begin
                    a_s[{k_r, 3'b000} +: 8] = bus.in_data;
                    k_s = k_r + 2'd1;
                    if (k_r == LAST_IDX) begin
                        state_s = S_B;
                    end else begin
                        state_s = S_A;
                    end
                end else begin
                    state_s = S_A;
                end
            end
            S_B: begin
                if (in_fire_s) begin
                    b_s[{k_r, 3'b000} +: 8] = bus.in_data;
                    k_s = k_r + 2'd1;
                    if (k_r == LAST_IDX) begin
                        state_s = S_EXEC;
                    end else begin
                        state_s = S_B;
                    end
                end else begin
                    state_s = S_B;
                end
            end
            S_EXEC: begin
                res_s   = alu_q;
                state_s = S_OUT;
            end
            S_OUT: begin
                if (out_fire_s) begin
                    k_s = k_r + 2'd1;
                    if (k_r == LAST_IDX) begin
                        state_s = S_HDR;
                    end else begin
                        state_s = S_OUT;
                    end
                end else begin
                    state_s = S_OUT;
                end
            end
            S_ERR: begin
                if (out_fire_s) begin
                    state_s = S_HDR;
                end else begin
                    state_s = S_ERR;
                end
            end
            default: begin
                state_s = S_HDR;
                k_s     = 2'd0;
            end
        endcase
    end

    // Handshake outputs are decoded from the next state so they can be registered.
    always_comb begin
        in_ready_s  = (state_s == S_HDR) || (state_s == S_A) || (state_s == S_B);
        out_valid_s = (state_s == S_OUT) || (state_s == S_ERR);
        if (state_s == S_OUT) begin
            out_data_s = byte_sel(res_s, k_s);
        end else if (state_s == S_ERR) begin
            out_data_s = ERR_BYTE;
        end else begin
            out_data_s = 8'h00;
        end
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_HDR;
            k_r           <= 2'd0;
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            alu_op        <= 3'b000;
            res_r         <= 32'd0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_s;
            k_r           <= k_s;
            alu_a         <= a_s;
            alu_b         <= b_s;
            alu_op        <= op_s;
            res_r         <= res_s;
            bus.in_ready  <= in_ready_s;
            bus.out_valid <= out_valid_s;
            bus.out_data  <= out_data_s;
            busy          <= (state_s != S_HDR);
        end
    end

endmodule

// File: tb/tb_alu_byte_frontend.sv
// Self-checking bench: directed table of frames, error/reset sequences and
// randomized frames checked against an arithmetic ALU reference.
module tb_alu_byte_frontend;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_q;
    logic        busy;
    int          n_checks;
    int          n_errors;
    logic        junk_en;

    alu_byte_frontend_if ifc ();

    alu_byte_frontend dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (ifc.slave),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_q  (alu_q),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return p[31:0];
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NAND: return ~(a & b);
            OP_NOR:  return ~(a | b);
            OP_NOT:  return ~a;
            default: return 32'd0;
        endcase
    endfunction

    // The ALU that normally sits beside the front end.
    always_comb alu_q = ref_alu(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        ifc.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        t = 0;
        while (!ifc.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, input int stall);
        int t;
        logic [7:0] hold;
        t = 0;
        while (!ifc.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("out_valid_timeout", 32'd0, 32'd1);
        hold = ifc.out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(ifc.out_valid), 32'd1);
            chk("hold_data", 32'(ifc.out_data), 32'(hold));
        end
        chk("in_ready_during_out", 32'(ifc.in_ready), 32'd0);
        ifc.out_ready = 1'b1;
        b = ifc.out_data;
        @(negedge clk);
        ifc.out_ready = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] hdr, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input int stall_idx, input int stall_n,
                             input int gap_max);
        logic [7:0]  ob;
        logic [31:0] got;
        send_byte(hdr, $urandom_range(gap_max, 0));
        chk("busy_mid_frame", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], $urandom_range(gap_max, 0));
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8], $urandom_range(gap_max, 0));
        chk("exec_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("exec_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        chk("alu_op", 32'(alu_op), 32'(hdr[2:0]));
        if (junk_en) begin
            ifc.in_valid = 1'b1;
            ifc.in_data  = 8'hFF;
        end
        @(negedge clk);
        chk("first_out_latency", 32'(ifc.out_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            recv_byte(ob, (i == stall_idx) ? stall_n : 0);
            got[8*i +: 8] = ob;
        end
        ifc.in_valid = 1'b0;
        chk("result", got, exp);
        chk("idle_out_valid", 32'(ifc.out_valid), 32'd0);
        chk("idle_in_ready", 32'(ifc.in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
        chk({nm, "_out_valid"}, 32'(ifc.out_valid), 32'd0);
        chk({nm, "_out_data"}, 32'(ifc.out_data), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_alu_a"}, alu_a, 32'd0);
        chk({nm, "_alu_b"}, alu_b, 32'd0);
        chk({nm, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stall_idx;
        int          stall_n;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [7:0]  ob;
        logic [7:0]  hdr;
        logic [31:0] ra;
        logic [31:0] rb;
        n_checks      = 0;
        n_errors      = 0;
        junk_en       = 1'b0;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = 8'h00;
        ifc.out_ready = 1'b0;

        vt[0] = '{8'h00, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, -1, 0};
        vt[1] = '{8'h01, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, -1, 0};
        vt[2] = '{8'h02, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, -1, 0};
        vt[3] = '{8'h07, 32'h0000_FFFF, 32'h0000_0000, 32'hFFFF_0000, -1, 0};
        vt[4] = '{8'h00, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1, 3};

        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_frame(vt[i].hdr, vt[i].a, vt[i].b, vt[i].exp, vt[i].stall_idx, vt[i].stall_n, 0);

        // Invalid header: one error byte, operands untouched.
        send_byte(8'h88, 0);
        chk("err_in_ready", 32'(ifc.in_ready), 32'd0);
        chk("err_alu_op", 32'(alu_op), 32'd0);
        chk("err_alu_a", alu_a, 32'h1234_5678);
        recv_byte(ob, 2);
        chk("err_byte", 32'(ob), 32'(ERR_BYTE));
        chk("err_single_byte", 32'(ifc.out_valid), 32'd0);
        chk("err_back_to_hdr", 32'(ifc.in_ready), 32'd1);
        run_frame(8'h03, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, -1, 0, 0);

        // Reset after header + two A bytes discards the partial frame.
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        rst = 1'b0;
        run_frame(8'h00, 32'd1, 32'd1, 32'h0000_0002, -1, 0, 0);

        // Randomized frames with input gaps, output stalls and idle upstream traffic.
        junk_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            hdr = {5'd0, 3'($urandom_range(7, 0))};
            ra  = $urandom;
            rb  = $urandom;
            if (n % 5 == 0) rb = 32'hFFFF_FFFF;
            run_frame(hdr, ra, rb, ref_alu(hdr[2:0], ra, rb),
                      $urandom_range(3, 0), $urandom_range(2, 0), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
